// File: rtl/bus_scheduler.sv
// bus_scheduler: shares one bus arbiter between three requesters
// (0 = fetch unit, 1 = data unit, 2 = interrupt unit).
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   rq[2:0]  in   request level per requester
//   op0..op2 in   4-bit opcode per requester, stable while its rq is high
//   done     in   arbiter completion level
//   gnt[2:0] out  one-hot bus owner, zero when idle
//   ack[2:0] out  one-cycle completion pulse to the owner
//   err      out  one-cycle watchdog-abort pulse, coincident with ack
//   request  out  one-cycle start pulse to the arbiter
//   req_op   out  opcode for the arbiter, zero unless request is high
//
// Build option
//   BUS_WATCHDOG_EN  defined: WAIT is abandoned after 16 cycles without done,
//                    signalled by err alongside ack.
//                    undefined: no watchdog, err is tied low.
//
// state  | meaning
// IDLE   | arbitrate among eligible requesters, latch winner
// ISSUE  | pulse request with the winner's opcode (done ignored)
// WAIT   | wait for done from the arbiter
// FINISH | pulse ack to the winner, then release the bus

module bus_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rq,
  input  logic [3:0] op0,
  input  logic [3:0] op1,
  input  logic [3:0] op2,
  input  logic       done,
  output logic [2:0] gnt,
  output logic [2:0] ack,
  output logic       err,
  output logic       request,
  output logic [3:0] req_op
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] gnt_q;
  logic [3:0] op_q;
  logic [1:0] last_q;
  logic       lock_en_q;
  logic [1:0] lock_id_q;

  logic [3:0] lock_op;
  logic       lock_rq;
  logic       lock_active;
  logic [2:0] eligible;
  logic [1:0] start_idx;
  logic [2:0] cand;
  logic       win_found;
  logic [1:0] win_idx;
  logic [3:0] win_op;
  logic [2:0] win_onehot;
  logic       timeout;

  function automatic logic is_batch(input logic [3:0] o);
    return (o == 4'd12) || (o == 4'd13);
  endfunction

  // Lock holds only while the locked requester keeps asking for a batch op;
  // otherwise it evaporates and normal arbitration runs in the same cycle.
  always_comb begin
    lock_op = op0;
    lock_rq = rq[0];
    case (lock_id_q)
      2'd1:    begin lock_op = op1; lock_rq = rq[1]; end
      2'd2:    begin lock_op = op2; lock_rq = rq[2]; end
      default: begin lock_op = op0; lock_rq = rq[0]; end
    endcase
    lock_active = lock_en_q && lock_rq && is_batch(lock_op);
    eligible    = lock_active ? (3'b001 << lock_id_q) : rq;
  end

  // Round-robin: first eligible requester starting after the last winner.
  always_comb begin
    start_idx = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, start_idx} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!win_found && eligible[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
    case (win_idx)
      2'd1:    win_op = op1;
      2'd2:    win_op = op2;
      default: win_op = op0;
    endcase
    win_onehot = 3'b001 << win_idx;
  end

`ifdef BUS_WATCHDOG_EN
  logic [3:0] wd_q;
  logic       timeout_q;

  assign timeout = (state_q == ST_WAIT) && !done && (wd_q == 4'hF);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q      <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      // timeout_q remembers why the last WAIT ended, read during FINISH
      timeout_q <= timeout;
      if (state_q == ST_ISSUE)
        wd_q <= 4'd0;
      else if (state_q == ST_WAIT && !done)
        wd_q <= wd_q + 4'd1;
    end
  end

  assign err = (state_q == ST_FINISH) && timeout_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|eligible) state_d = ST_ISSUE;
      ST_ISSUE:  state_d = ST_WAIT;
      ST_WAIT:   if (done || timeout) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 3'b000;
      op_q      <= 4'd0;
      last_q    <= 2'd2;
      lock_en_q <= 1'b0;
      lock_id_q <= 2'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          lock_en_q <= (|eligible) && is_batch(win_op);
          if (|eligible) begin
            gnt_q     <= win_onehot;
            op_q      <= win_op;
            last_q    <= win_idx;
            lock_id_q <= win_idx;
          end
        end
        ST_WAIT:   if (timeout) lock_en_q <= 1'b0;
        ST_FINISH: gnt_q <= 3'b000;
        default:   ;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign request = (state_q == ST_ISSUE);
  assign req_op  = request ? op_q : 4'd0;
  assign ack     = (state_q == ST_FINISH) ? gnt_q : 3'b000;

endmodule

// File: doc/bus_scheduler.md
BUS_SCHEDULER -- requirements
Module: bus_scheduler

Interface
REQ-001 clk  in  1  single system clock; all state changes on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 rq  in  3  per-requester request level; bit 0 fetch unit, bit 1 data unit, bit 2 interrupt unit.
REQ-004 op0, op1, op2  in  4 each  per-requester bus opcode (arbiter encoding 0..15); requester holds it stable while its rq is high.
REQ-005 gnt  out  3  one-hot, current owner of the bus; all-zero when idle.
REQ-006 ack  out  3  one-cycle completion pulse to the granted requester.
REQ-007 err  out  1  one-cycle watchdog-abort pulse, coincident with ack.
REQ-008 request  out  1  one-cycle start pulse to the bus arbiter.
REQ-009 req_op  out  4  opcode for the arbiter; valid while request is high, 0 otherwise.
REQ-010 done  in  1  arbiter completion level.

Function
REQ-011 The FSM SHALL have states IDLE, ISSUE, WAIT and FINISH.
REQ-012 IDLE: if any eligible rq bit is high, select a winner, register gnt and req_op, and go to ISSUE; otherwise stay in IDLE with gnt=0.
REQ-013 ISSUE (exactly 1 cycle): request=1, req_op=winner's opcode; done is ignored in this cycle; next state is WAIT.
REQ-014 WAIT: request=0; when done=1, go to FINISH.
REQ-015 FINISH (exactly 1 cycle): ack[winner]=1, gnt held; next state is IDLE.
REQ-016 Latency: rq sampled high in IDLE at cycle T gives request at T+1 and first done sample at T+2; done seen at cycle D gives ack at D+1; the earliest next request is at D+3.
REQ-017 Arbitration SHALL be round-robin: search starts at (last winner + 1) mod 3.
REQ-018 Batch lock: a winner with opcode 12 (BTRWR) or 13 (BTRRD) sets the lock to that requester.
REQ-019 While the lock is set, only the locked requester is eligible, and only if its opcode is 12 or 13.
REQ-020 The lock SHALL clear in IDLE when the locked requester has rq=0 or presents any other opcode; arbitration proceeds normally in that same cycle.
REQ-021 If a requester drops rq after being granted, the operation still completes and ack is still pulsed.
REQ-022 Opcodes the arbiter completes immediately (0-4, 14) SHALL still traverse ISSUE, WAIT (1 cycle) and FINISH.
REQ-023 gnt SHALL remain constant from ISSUE through FINISH.
REQ-024 ack and err SHALL never be high outside FINISH.

Reset
REQ-025 While reset is high: state=IDLE, request=0, req_op=0, gnt=0, ack=0, err=0, lock cleared, last-winner pointer=2 so requester 0 wins first.
REQ-026 Reset during ISSUE, WAIT or FINISH SHALL abort with no ack; arbitration resumes on the first cycle after reset deasserts.

Configuration
REQ-027 Macro BUS_WATCHDOG_EN defined: a 4-bit counter clears on entry to WAIT and increments each WAIT cycle with done=0; when it reaches 15 with done still 0, go to FINISH, pulse err with ack, and clear the lock.
REQ-028 Macro BUS_WATCHDOG_EN undefined: no counter is built, err is tied 0, and WAIT lasts indefinitely until done.

Verification
REQ-029 After reset, rq=3'b111, all op=9, done high 3 cycles after each request -> grants in order 0,1,2,0; one ack per grant; request spacing of 6 cycles.
REQ-030 rq[1] with op1=12, rq[0] held with op0=8 -> requester 1 is granted repeatedly while op1=12; after op1 changes to 10, requester 0 is granted next.
REQ-031 op0=0, done constantly 1 -> request at T+1, ack[0] at T+3, gnt=0 at T+4.
REQ-032 Reset asserted in WAIT -> next cycle gnt=0, request=0, no ack; after release with rq=3'b100, requester 2 is granted.
REQ-033 BUS_WATCHDOG_EN defined, done held 0 -> err and ack[winner] high together, exactly one cycle, 16 cycles after WAIT entry.
REQ-034 rq[2] dropped in the cycle after ISSUE -> ack[2] still pulses when done arrives; no new request is issued.
